// File: rtl/ss_ctrl_pkg.sv
// Shared types and defaults for the serial shift-register controller.
// Holds the controller state encoding and the default frame/divider widths.
package ss_ctrl_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DIV_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ss_tick_gen.sv
// Bit-period prescaler: counts 0..div and emits a one-cycle tick at the top.
// Held at zero while clr is high, so the first tick after release lands div+1 cycles later.
module ss_tick_gen
  import ss_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] CNT_ZERO = DIV_W'(0);

  logic [DIV_W-1:0] r_cnt;
  logic             w_at_top;

  assign w_at_top = (r_cnt == div);
  assign tick     = !clr && w_at_top;

  // Prescaler count, wrapping to zero on the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= CNT_ZERO;
    end else if (clr) begin
      r_cnt <= CNT_ZERO;
    end else if (w_at_top) begin
      r_cnt <= CNT_ZERO;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/ss_shift_ctrl.sv
// Serial shift-register controller: shifts a parallel word out MSB first while
// capturing the returned serial stream, one bit per prescaled bit period.
module ss_shift_ctrl
  import ss_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             shift_en,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   BIT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   BIT_ZERO = CNT_W'(0);
  localparam logic [WIDTH-1:0]   WORD_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-2:0]   RXSH_ZERO = {(WIDTH-1){1'b0}};
  localparam logic [DIV_W-1:0]   DIV_ZERO  = {DIV_W{1'b0}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_tx_sh;
  logic [WIDTH-2:0] r_rx_sh;
  logic [WIDTH-1:0] r_rx_data;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_tx_ready;
  logic             r_busy;
  logic             r_rx_valid;

  logic             w_clr;
  logic             w_tick;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_rx_nxt;

  assign w_clr    = (r_state != ST_SHIFT);
  assign w_accept = (r_state == ST_IDLE) && tx_valid && !abort;
  // An abort cancels the strobe of its own cycle as well as all later ones.
  assign w_shift  = (r_state == ST_SHIFT) && w_tick && !abort;
  assign w_last   = w_shift && (r_bit_cnt == LAST_BIT);
  // The top rx bit is never stored: the final bit goes straight into rx_data.
  assign w_rx_nxt = {r_rx_sh, ser_in};

  ss_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .div (r_div),
    .tick(w_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; unknown encodings fall back to IDLE.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift datapath: load on accept, shift on each strobe, publish rx on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_sh   <= WORD_ZERO;
      r_rx_sh   <= RXSH_ZERO;
      r_rx_data <= WORD_ZERO;
      r_bit_cnt <= BIT_ZERO;
      r_div     <= DIV_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tx_sh   <= tx_data;
            r_rx_sh   <= RXSH_ZERO;
            r_bit_cnt <= BIT_ZERO;
            r_div     <= div;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            r_tx_sh <= WORD_ZERO;
          end else if (w_shift) begin
            r_tx_sh   <= {r_tx_sh[WIDTH-2:0], 1'b0};
            r_rx_sh   <= w_rx_nxt[WIDTH-2:0];
            r_bit_cnt <= r_bit_cnt + BIT_ONE;
            if (w_last) begin
              r_rx_data <= w_rx_nxt;
            end
          end
        end
        ST_DONE: begin
          r_tx_sh <= WORD_ZERO;
        end
        default: begin
          r_tx_sh <= WORD_ZERO;
        end
      endcase
    end
  end

  // Status outputs registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_tx_ready <= (w_state_nxt == ST_IDLE);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_rx_valid <= (w_state_nxt == ST_DONE);
    end
  end

  assign tx_ready = r_tx_ready;
  assign busy     = r_busy;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign ser_out  = r_tx_sh[WIDTH-1];
  assign shift_en = w_shift;

endmodule

// File: tb/tb_ss_shift_ctrl.sv
// Scoreboard bench for ss_shift_ctrl: ser_in is looped back from ser_out through
// an 8-stage register clocked by shift_en, so each frame returns the previous contents.
module tb_ss_shift_ctrl;

  localparam int W  = 8;
  localparam int DW = 4;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [W-1:0]  tx_data  = 8'h00;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] div      = 4'd0;
  logic          abort    = 1'b0;
  logic          ser_in;
  logic          tx_ready;
  logic          ser_out;
  logic          shift_en;
  logic [W-1:0]  rx_data;
  logic          rx_valid;
  logic          busy;

  logic [7:0]    ext = 8'h00;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    logic [W-1:0] rx;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ss_shift_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .div     (div),
    .abort   (abort),
    .ser_out (ser_out),
    .ser_in  (ser_in),
    .shift_en(shift_en),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // External 8-stage shift register closing the loop.
  always @(posedge clk) begin
    if (shift_en) ext <= {ext[6:0], ser_out};
  end
  assign ser_in = ext[7];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected event within bound", name);
  endtask

  // Monitor: tracks accepts and strobes, pops the scoreboard on every rx_valid.
  initial begin : monitor
    int   acc_cyc;
    int   se_cnt;
    logic prev_busy;
    logic prev_se;
    logic prev_ser;
    acc_cyc = 0; se_cnt = 0; prev_busy = 1'b0; prev_se = 1'b0; prev_ser = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        prev_se   = 1'b0;
      end else begin
        if (busy && prev_busy && !prev_se && !rx_valid)
          chk("ser_out_stable", ser_out, prev_ser);
        if (shift_en) se_cnt++;
        if (tx_valid && tx_ready && !abort) begin
          acc_cyc = cyc;
          se_cnt  = 0;
        end
        if (rx_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rx_valid: got pulse with rx_data 0x%0h, expected none", rx_data);
          end else begin
            mon_e = exp_q.pop_front();
            chk("rx_data", rx_data, mon_e.rx);
            chk("frame_latency", cyc - acc_cyc, mon_e.lat);
            chk("shift_en_count", se_cnt, W);
          end
        end
        prev_busy = busy;
        prev_se   = shift_en;
        prev_ser  = ser_out;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) timeout_fail("wait_ready");
  endtask

  task automatic wait_rx();
    int n = 0;
    @(negedge clk);
    while (!rx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rx_valid) timeout_fail("wait_rx_valid");
  endtask

  task automatic wait_shifts(input int cnt);
    int seen = 0;
    int n    = 0;
    while (seen < cnt && n < 300) begin
      @(negedge clk);
      if (shift_en) seen++;
      n++;
    end
    if (seen < cnt) timeout_fail("wait_shift_en");
  endtask

  // Issue one word; returns one cycle after the accept edge.
  task automatic send(input logic [W-1:0] data, input logic [DW-1:0] d,
                      input bit push, input logic [W-1:0] exp_rx);
    wait_ready();
    @(posedge clk); #1;
    tx_data  = data;
    div      = d;
    tx_valid = 1'b1;
    if (push) exp_q.push_back('{rx: exp_rx, lat: W * (int'(d) + 1) + 1});
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  initial begin : stim
    int           acc [3];
    logic [W-1:0] b2b_tx [3];
    logic [W-1:0] b2b_rx [3];
    int           n;
    b2b_tx[0] = 8'h11; b2b_tx[1] = 8'h22; b2b_tx[2] = 8'h33;
    b2b_rx[0] = 8'hFF; b2b_rx[1] = 8'h11; b2b_rx[2] = 8'h22;

    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic frame at div=0, then a slow frame at div=3.
    send(8'hA5, 4'd0, 1'b1, 8'h00);
    wait_rx();
    send(8'h3C, 4'd3, 1'b1, 8'hA5);
    wait_rx();

    // Abort after the third strobe.
    send(8'h96, 4'd0, 1'b0, 8'h00);
    wait_shifts(3);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_cycle_shift_en", shift_en, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_tx_ready", tx_ready, 1);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_shift_en", shift_en, 0);
      @(negedge clk);
    end
    chk("abort_rx_data_kept", rx_data, 8'hA5);

    // Abort together with tx_valid in IDLE must not accept.
    @(posedge clk); #1;
    tx_data = 8'h77; tx_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_tx_ready", tx_ready, 1);

    // div changed mid-frame, then the next frame picks up 8-cycle bits.
    send(8'h5A, 4'd0, 1'b1, 8'hE4);
    repeat (2) @(posedge clk);
    #1 div = 4'd7;
    wait_rx();
    send(8'hC3, 4'd7, 1'b1, 8'h5A);
    wait_rx();

    // Asynchronous reset mid-frame after two strobes.
    send(8'h81, 4'd0, 1'b1, 8'h00);
    wait_shifts(2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_tx_ready", tx_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_shift_en", shift_en, 0);
    chk("midrst_ser_out", ser_out, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_rx_data", rx_data, 0);
    @(negedge clk); #1;
    rst = 1'b0;

    // 0xFF frame after reset, with abort during DONE (must be ignored).
    send(8'hFF, 4'd0, 1'b1, 8'h0E);
    repeat (8) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_ready();

    // tx_valid held high across three frames.
    @(posedge clk); #1;
    tx_valid = 1'b1;
    div      = 4'd0;
    for (int k = 0; k < 3; k++) begin
      tx_data = b2b_tx[k];
      exp_q.push_back('{rx: b2b_rx[k], lat: W + 1});
      n = 0;
      @(negedge clk);
      while (!tx_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!tx_ready) timeout_fail("b2b_accept");
      acc[k] = cyc;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    chk("b2b_spacing_0", acc[1] - acc[0], W + 2);
    chk("b2b_spacing_1", acc[2] - acc[1], W + 2);
    wait_rx();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
